// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/bubble controller with fixed-latency data-memory wait FSM
// Optional hazard performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int DMEM_LATENCY = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             pc_src_ex,
    input  logic             mem_read_mem,
    input  logic             mem_write_mem,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_id,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             bubble_wb,
    output logic             dmem_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] load_use_count
);
    localparam int CW = $clog2(DMEM_LATENCY) + 1;
    localparam bit HAS_WAIT = (DMEM_LATENCY > 1);
    localparam logic [CW-1:0] WAIT_INIT = HAS_WAIT ? CW'(DMEM_LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_op, load_use;
    logic          freeze, hazard_en;
    logic          redirect_hit, load_use_hit;

    assign mem_op   = mem_read_mem | mem_write_mem;
    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rd_ex == rs1_id)) || (rs2_used_id && (rd_ex == rs2_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        freeze       = 1'b0;
        hazard_en    = 1'b0;
        redirect_hit = 1'b0;
        load_use_hit = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        bubble_id    = 1'b0;
        bubble_ex    = 1'b0;
        bubble_mem   = 1'b0;
        bubble_wb    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_op && HAS_WAIT) begin
                    freeze  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = ST_DWAIT;
                end else begin
                    hazard_en = 1'b1;
                end
            end
            ST_DWAIT: begin
                // Release cycle ignores mem_op so the op still in MEM cannot retrigger.
                if (cnt_q != '0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    hazard_en = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end

        // A redirect squashes the ID instruction, so its load-use hazard is moot.
        if (hazard_en) begin
            if (pc_src_ex) begin
                bubble_id    = 1'b1;
                bubble_ex    = 1'b1;
                redirect_hit = 1'b1;
            end else if (load_use) begin
                stall_if     = 1'b1;
                stall_id     = 1'b1;
                bubble_ex    = 1'b1;
                load_use_hit = 1'b1;
            end
        end

        if (!rst_n) begin
            stall_if     = 1'b0;
            stall_id     = 1'b0;
            stall_ex     = 1'b0;
            stall_mem    = 1'b0;
            bubble_id    = 1'b1;
            bubble_ex    = 1'b1;
            bubble_mem   = 1'b1;
            bubble_wb    = 1'b1;
            redirect_hit = 1'b0;
            load_use_hit = 1'b0;
        end
    end

    assign dmem_busy = rst_n && (state_q == ST_DWAIT);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_count_q, load_use_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q   <= '0;
            flush_count_q    <= '0;
            load_use_count_q <= '0;
        end else begin
            if (stall_if)     stall_cycles_q   <= stall_cycles_q + CNT_W'(1);
            if (redirect_hit) flush_count_q    <= flush_count_q + CNT_W'(1);
            if (load_use_hit) load_use_count_q <= load_use_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign flush_count    = flush_count_q;
    assign load_use_count = load_use_count_q;
`else
    logic unused_perf;
    assign unused_perf    = redirect_hit | load_use_hit;
    assign stall_cycles   = '0;
    assign flush_count    = '0;
    assign load_use_count = '0;
`endif
endmodule
